egg_countdown: RTL and testbench

- MM:SS countdown core of the egg timer, directly downstream of the 1 Hz divider.
- Drives the divider's enable input.
- Consumes the divider's square-wave output as tick_in, in the same clk_in domain.
- Holds a BCD preset, counts down one second per tick_in rising edge, and raises alarm at 00:00.

---
 rtl/egg_countdown_if.sv | 29 ++
 rtl/egg_countdown.sv | 148 ++++++++++++++
 tb/tb_egg_countdown.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_countdown_if.sv
// Signal bundle between the egg timer control/divider side and the MM:SS countdown core.
// dbg_state mirrors the core's FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3) for observation.
interface egg_countdown_if;
  logic       tick_in;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic       div_enable;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       alarm;
  logic       load_err;
  logic [1:0] dbg_state;

  // Inputs are levels sampled on every clk_in edge; there is no valid/ready
  // handshake. load_err is a one-cycle response to a rejected load.
  modport master (
    output tick_in, load, load_min, load_sec, start, stop,
    input  div_enable, min_bcd, sec_bcd, running, alarm, load_err, dbg_state
  );

  modport slave (
    input  tick_in, load, load_min, load_sec, start, stop,
    output div_enable, min_bcd, sec_bcd, running, alarm, load_err, dbg_state
  );
endinterface

// File: rtl/egg_countdown.sv
// MM:SS BCD countdown core of the egg timer, fed by the 1 Hz divider's square wave.
// Optional macro EGG_ALARM_TIMEOUT_EN: alarm auto-clears after ALARM_SECS ticks in DONE.
module egg_countdown #(
  parameter int ALARM_SECS = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  egg_countdown_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  sec_q, sec_d;
  logic        load_err_q, load_err_d;
  logic        tick_dly_q;
  logic        tick_pulse;
  logic        load_ok;
  logic [15:0] dec_val;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick_pulse = bus.tick_in & ~tick_dly_q;
  assign dec_val    = bcd_dec({min_q, sec_q});
  assign load_ok    = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                      (bus.load_sec[7:4] <= 4'd5) && (bus.load_sec[3:0] <= 4'd9);

`ifdef EGG_ALARM_TIMEOUT_EN
  localparam int CW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS);
  logic [CW-1:0] acnt_q, acnt_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) acnt_q <= '0;
    else        acnt_q <= acnt_d;
  end
`else
  localparam int alarm_secs_unused = ALARM_SECS;
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      load_err_q <= 1'b0;
      tick_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      load_err_q <= load_err_d;
      tick_dly_q <= bus.tick_in;
    end
  end

  // Priority per cycle: stop > load > start > tick_pulse.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    load_err_d = 1'b0;
`ifdef EGG_ALARM_TIMEOUT_EN
    acnt_d     = acnt_q;
`endif
    case (state_q)
      IDLE, PAUSE: begin
        if (bus.stop) begin
          if (state_q == PAUSE) state_d = IDLE;
        end else if (bus.load) begin
          if (load_ok) begin
            min_d = bus.load_min;
            sec_d = bus.load_sec;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (bus.start && ({min_q, sec_q} != 16'h0000)) begin
          // A zero value never enters RUN, so the decrement cannot underflow.
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (tick_pulse) begin
          {min_d, sec_d} = dec_val;
          if (dec_val == 16'h0000) begin
            state_d = DONE;
`ifdef EGG_ALARM_TIMEOUT_EN
            acnt_d  = '0;
`endif
          end
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
`ifdef EGG_ALARM_TIMEOUT_EN
          acnt_d  = '0;
        end else if (tick_pulse) begin
          if (acnt_q == CW'(ALARM_SECS - 1)) begin
            state_d = IDLE;
            acnt_d  = '0;
          end else begin
            acnt_d  = acnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.min_bcd   = min_q;
  assign bus.sec_bcd   = sec_q;
  assign bus.running   = (state_q == RUN);
  assign bus.alarm     = (state_q == DONE);
  assign bus.load_err  = load_err_q;
  assign bus.dbg_state = state_q;
`ifdef EGG_ALARM_TIMEOUT_EN
  assign bus.div_enable = (state_q == RUN) || (state_q == DONE);
`else
  assign bus.div_enable = (state_q == RUN);
`endif

endmodule

// File: tb/tb_egg_countdown.sv
// Directed bench for egg_countdown: tick results are predicted from a seconds model
// and checked through an expected-value queue.
module tb_egg_countdown;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   cur_secs = 0;
  logic [15:0] exp_q[$];

  egg_countdown_if bus ();

`ifdef EGG_ALARM_TIMEOUT_EN
  egg_countdown #(.ALARM_SECS(3)) dut (.clk_in(clk_in), .reset(reset), .bus(bus));
  localparam logic DONE_DIV = 1'b1;
`else
  egg_countdown dut (.clk_in(clk_in), .reset(reset), .bus(bus));
  localparam logic DONE_DIV = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    bus.load_min = m;
    bus.load_sec = s;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  // Rising tick while counting: predict the new value, then compare after the edge.
  task automatic tick_run(input string tag);
    logic [15:0] e;
    bus.tick_in = 1'b1;
    cur_secs--;
    exp_q.push_back(to_bcd(cur_secs));
    step();
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {bus.min_bcd, bus.sec_bcd}, e);
    end
    bus.tick_in = 1'b0;
    step();
  endtask

  task automatic tick_hi();
    bus.tick_in = 1'b1;
    step();
  endtask

  task automatic tick_lo();
    bus.tick_in = 1'b0;
    step();
  endtask

  initial begin
    bus.tick_in  = 1'b0;
    bus.load     = 1'b0;
    bus.load_min = 8'h00;
    bus.load_sec = 8'h00;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;

    // Reset values
    #12;
    chk("rst_value", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
    chk("rst_running", 16'(bus.running), 16'd0);
    chk("rst_alarm", 16'(bus.alarm), 16'd0);
    chk("rst_div_en", 16'(bus.div_enable), 16'd0);
    chk("rst_load_err", 16'(bus.load_err), 16'd0);
    chk("rst_state", 16'(bus.dbg_state), 16'(S_IDLE));
    reset = 1'b1;
    step();

    // 01:00 counts down three seconds
    do_load(8'h01, 8'h00);
    cur_secs = 60;
    chk("load_0100", {bus.min_bcd, bus.sec_bcd}, 16'h0100);
    chk("load_ok_err", 16'(bus.load_err), 16'd0);
    pulse_start();
    chk("run_running", 16'(bus.running), 16'd1);
    chk("run_div_en", 16'(bus.div_enable), 16'd1);
    tick_run("tick_0059");
    tick_run("tick_0058");
    tick_run("tick_0057");
    do_load(8'h05, 8'h00);
    chk("load_ignored_run", {bus.min_bcd, bus.sec_bcd}, 16'h0057);
    pulse_stop();
    chk("stop_to_pause", 16'(bus.dbg_state), 16'(S_PAUSE));
    pulse_stop();
    chk("stop_to_idle", 16'(bus.dbg_state), 16'(S_IDLE));
    chk("idle_hold", {bus.min_bcd, bus.sec_bcd}, 16'h0057);

    // 00:02 to DONE
    do_load(8'h00, 8'h02);
    cur_secs = 2;
    pulse_start();
    tick_run("tick_0001");
    tick_run("tick_0000");
    chk("done_alarm", 16'(bus.alarm), 16'd1);
    chk("done_running", 16'(bus.running), 16'd0);
    chk("done_state", 16'(bus.dbg_state), 16'(S_DONE));
    chk("done_div_en", 16'(bus.div_enable), 16'(DONE_DIV));
    pulse_stop();
    chk("done_stop_alarm", 16'(bus.alarm), 16'd0);
    chk("done_stop_state", 16'(bus.dbg_state), 16'(S_IDLE));

    // stop coincident with a tick edge drops the tick
    do_load(8'h00, 8'h31);
    cur_secs = 31;
    pulse_start();
    tick_run("tick_0030");
    bus.tick_in = 1'b1;
    bus.stop    = 1'b1;
    step();
    bus.stop    = 1'b0;
    chk("stop_tick_value", {bus.min_bcd, bus.sec_bcd}, 16'h0030);
    chk("stop_tick_state", 16'(bus.dbg_state), 16'(S_PAUSE));
    chk("pause_div_en", 16'(bus.div_enable), 16'd0);
    tick_lo();
    for (int i = 0; i < 3; i++) begin
      tick_hi();
      tick_lo();
    end
    chk("pause_ticks_value", {bus.min_bcd, bus.sec_bcd}, 16'h0030);
    pulse_start();
    chk("resume_state", 16'(bus.dbg_state), 16'(S_RUN));
    tick_run("tick_0029");
    pulse_stop();
    pulse_stop();

    // load validation
    do_load(8'h00, 8'h60);
    chk("bad_sec_err", 16'(bus.load_err), 16'd1);
    chk("bad_sec_value", {bus.min_bcd, bus.sec_bcd}, 16'h0029);
    step();
    chk("bad_sec_err_clr", 16'(bus.load_err), 16'd0);
    do_load(8'h0A, 8'h00);
    chk("bad_min_err", 16'(bus.load_err), 16'd1);
    chk("bad_min_value", {bus.min_bcd, bus.sec_bcd}, 16'h0029);
    step();
    chk("bad_min_err_clr", 16'(bus.load_err), 16'd0);
    do_load(8'h00, 8'h00);
    pulse_start();
    chk("zero_start_state", 16'(bus.dbg_state), 16'(S_IDLE));
    chk("zero_start_running", 16'(bus.running), 16'd0);

    // wraps
    do_load(8'h10, 8'h00);
    cur_secs = 600;
    pulse_start();
    tick_run("wrap_0959");
    pulse_stop();
    pulse_stop();
    do_load(8'h99, 8'h59);
    cur_secs = 99 * 60 + 59;
    pulse_start();
    tick_run("wrap_9958");
    pulse_stop();
    pulse_stop();

    // alarm hold / timeout
    do_load(8'h00, 8'h01);
    cur_secs = 1;
    pulse_start();
    tick_run("tick_to_done");
    chk("alarm_set", 16'(bus.alarm), 16'd1);
`ifdef EGG_ALARM_TIMEOUT_EN
    tick_hi();
    chk("timeout_t1", 16'(bus.alarm), 16'd1);
    tick_lo();
    tick_hi();
    chk("timeout_t2", 16'(bus.alarm), 16'd1);
    tick_lo();
    tick_hi();
    chk("timeout_t3_alarm", 16'(bus.alarm), 16'd0);
    chk("timeout_t3_state", 16'(bus.dbg_state), 16'(S_IDLE));
    tick_lo();
`else
    for (int i = 0; i < 5; i++) begin
      tick_hi();
      tick_lo();
    end
    chk("hold_alarm", 16'(bus.alarm), 16'd1);
    chk("hold_value", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
    pulse_stop();
`endif

    // asynchronous reset mid-count
    do_load(8'h00, 8'h05);
    pulse_start();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_value", {bus.min_bcd, bus.sec_bcd}, 16'h0000);
    chk("async_rst_state", 16'(bus.dbg_state), 16'(S_IDLE));
    chk("async_rst_div_en", 16'(bus.div_enable), 16'd0);
    reset = 1'b1;
    step();

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
